register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the single-write, dual-read RV32I register file.
- Configurable depth, width, read-port count and write-port count.
- Optional write-to-read bypass and an architectural zero register.
- A sequential clear engine zeroes the array one entry per cycle after reset or on request. Sits between decode (read addresses) and writeback (write ports) in the core pipeline.

Parameters:
- DATA_WIDTH, 32, width of each register in bits.
- NUM_REGISTER, 32, number of entries; must be a power of two and at least 2. AW = $clog2(NUM_REGISTER).
- NUM_RD_PORTS, 2, number of combinational read ports (1..4).
- NUM_WR_PORTS, 1, number of synchronous write ports (1..2).
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1, a read of an address written in the same cycle returns the write data.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  request a full array clear; sampled only while idle.
- busy_o  out  1  high while the clear engine is running.
- we_i  in  NUM_WR_PORTS  per-port write enable.
- rd_addr_i  in  NUM_WR_PORTS*AW  write addresses; port p occupies bits [p*AW +: AW].
- rd_i  in  NUM_WR_PORTS*DATA_WIDTH  write data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- rs_addr_i  in  NUM_RD_PORTS*AW  read addresses, packed the same way.
- rs_o  out  NUM_RD_PORTS*DATA_WIDTH  read data, packed the same way.

Behaviour:
- FSM states: IDLE, CLEAR. Counter clr_cnt is AW bits.
- Reset (rst_i=1 at a rising edge):
  - State goes to CLEAR, clr_cnt=0, busy_o=1 in the following cycle.
  - Reset has priority over everything; asserting it mid-clear restarts the sweep at 0.
- CLEAR state:
  - Each cycle, entry clr_cnt is written with 0 and clr_cnt increments.
  - When clr_cnt == NUM_REGISTER-1, that entry is cleared and the state returns to IDLE.
  - busy_o is high for exactly NUM_REGISTER cycles after reset deassertion or clear acceptance.
  - we_i is ignored; no write port updates the array.
  - clear_i is ignored.
  - All rs_o lanes read 0.
- IDLE state:
  - clear_i=1 at an edge moves the state to CLEAR with clr_cnt=0.
  - Writes presented in that same cycle are still committed; the sweep then zeroes them.
- Writes (IDLE only):
  - For each port with we_i[p]=1, entry rd_addr[p] takes rd[p] at the rising edge.
  - If ZERO_REG=1 and the address is 0, the write is discarded.
  - If two ports target the same address, the higher-index port wins.
- Reads:
  - Combinational; rs_o[k] = array[rs_addr[k]], no clock latency.
  - If ZERO_REG=1 and the address is 0, the result is 0 regardless of bypass.
  - If BYPASS=1, state is IDLE, and some enabled write port targets rs_addr[k] (nonzero when ZERO_REG=1), rs_o[k] returns that port's rd data. Highest-index matching port wins.
  - If BYPASS=0, the old value is returned until after the edge.
- Reset values:
  - busy_o=1 from the edge where rst_i is sampled high until the sweep completes.
  - rs_o=0 during reset and sweep.
  - Array contents are undefined until the sweep clears them; they are never observable as nonzero.
- No wrap-around hazard: clr_cnt stops at the last entry, and state transitions out rather than wrapping.

Test Plan:
- Reset then sweep: assert rst_i for 2 cycles, release -> busy_o=1 for exactly 32 cycles, then 0; all 32 entries read 00000000 afterward.
- Basic write/read (defaults): we=1, rd_addr=1, rd=00000001, rs_addr[0]=1, rs_addr[1]=2 -> same-cycle bypass rs_o[0]=00000001, rs_o[1]=00000000; after the edge with we=0, rs_o[0] is still 00000001.
- Zero register: write ffffffff to addr 0, and write ffffffff to addr 31 on the next cycle -> reading addr 0 gives 00000000, addr 31 gives ffffffff, both with and without bypass.
- Write collision (NUM_WR_PORTS=2): both ports write addr 5, port0 data 11111111, port1 data 22222222 -> same-cycle bypass and post-edge read both give 22222222.
- Clear mid-run:
  - Setup: fill addr 1..31 with the value of the address, then pulse clear_i with a concurrent write of aaaaaaaa to addr 7.
  - Expected: busy_o high for 32 cycles; writes during busy are dropped; all reads 0 during and after the sweep.
  - Then rst_i pulsed at sweep cycle 10 -> busy_o stays high and the sweep restarts (32 more cycles).
- BYPASS=0 build: write deadbeef to addr 3 while reading addr 3 -> old value 00000000 in the same cycle, deadbeef after the edge.

Source files
------------

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// an architectural zero register and a one-entry-per-cycle clear engine.
module register_file_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGISTER = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(NUM_REGISTER)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  output logic                               busy_o,
  input  logic [NUM_WR_PORTS-1:0]            we_i,
  input  logic [NUM_WR_PORTS*AW-1:0]         rd_addr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] rd_i,
  input  logic [NUM_RD_PORTS*AW-1:0]         rs_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_o
);

  // clear_i / busy_o: a request is accepted on any rising edge where busy_o
  // is low; busy_o then stays high for exactly NUM_REGISTER cycles. Requests
  // seen while busy_o is high are dropped, not queued.

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGISTER - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGISTER];

  logic [AW-1:0]         wr_addr [NUM_WR_PORTS];
  logic [DATA_WIDTH-1:0] wr_data [NUM_WR_PORTS];
  logic                  wr_en   [NUM_WR_PORTS];
  logic [AW-1:0]         rs_addr [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0] rd_data [NUM_RD_PORTS];

  // Unpack the flat buses; wr_en already folds in the zero-register discard.
  always_comb begin
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      wr_addr[p] = rd_addr_i[p*AW +: AW];
      wr_data[p] = rd_i[p*DATA_WIDTH +: DATA_WIDTH];
      wr_en[p]   = we_i[p] && !((ZERO_REG != 0) && (wr_addr[p] == '0));
    end
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rs_addr[k] = rs_addr_i[k*AW +: AW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        // Leave on the last entry instead of letting the counter wrap.
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign busy_o = (state_q == ST_CLEAR);

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_en[p]) begin
            mem_q[wr_addr[p]] <= wr_data[p];
          end
        end
      end
    end
  end

  // Read path: masking during the sweep hides the uninitialised array.
  always_comb begin
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rd_data[k] = mem_q[rs_addr[k]];
      if ((BYPASS != 0) && (state_q == ST_IDLE)) begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_en[p] && (wr_addr[p] == rs_addr[k])) begin
            rd_data[k] = wr_data[p];
          end
        end
      end
      if ((ZERO_REG != 0) && (rs_addr[k] == '0)) begin
        rd_data[k] = '0;
      end
      if (state_q == ST_CLEAR) begin
        rd_data[k] = '0;
      end
    end
  end

  always_comb begin
    rs_o = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rs_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[k];
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a dual-write bypassing build and a single-write
// non-bypassing build, checked through an expected-value queue.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam int S_A0 = 0;
  localparam int S_A1 = 1;
  localparam int S_ABUSY = 2;
  localparam int S_B0 = 3;
  localparam int S_B1 = 4;
  localparam int S_BBUSY = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic              clear_a, busy_a;
  logic [1:0]        we_a;
  logic [2*AW-1:0]   wa_a;
  logic [2*DW-1:0]   wd_a;
  logic [NR*AW-1:0]  ra_a;
  logic [NR*DW-1:0]  rs_a;

  logic              clear_b, busy_b;
  logic [0:0]        we_b;
  logic [AW-1:0]     wa_b;
  logic [DW-1:0]     wd_b;
  logic [NR*AW-1:0]  ra_b;
  logic [NR*DW-1:0]  rs_b;

  register_file_mp #(
    .DATA_WIDTH(DW), .NUM_REGISTER(32), .NUM_RD_PORTS(NR),
    .NUM_WR_PORTS(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .busy_o(busy_a),
    .we_i(we_a), .rd_addr_i(wa_a), .rd_i(wd_a),
    .rs_addr_i(ra_a), .rs_o(rs_a)
  );

  register_file_mp #(
    .DATA_WIDTH(DW), .NUM_REGISTER(32), .NUM_RD_PORTS(NR),
    .NUM_WR_PORTS(1), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .busy_o(busy_b),
    .we_i(we_b), .rd_addr_i(wa_b), .rd_i(wd_b),
    .rs_addr_i(ra_b), .rs_o(rs_b)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            sel_q[$];
  int            cyc_q[$];
  string         name_q[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pick(int sel);
    case (sel)
      S_A0:    return rs_a[0 +: DW];
      S_A1:    return rs_a[DW +: DW];
      S_ABUSY: return {31'b0, busy_a};
      S_B0:    return rs_b[0 +: DW];
      S_B1:    return rs_b[DW +: DW];
      default: return {31'b0, busy_b};
    endcase
  endfunction

  // monitor: compares every expectation registered for the current cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      logic [DW-1:0] got;
      got = pick(sel_q[0]);
      n_cmp++;
      if (got !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s (cycle %0d): got %08h expected %08h",
                 name_q[0], cyc, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      void'(sel_q.pop_front());
      void'(cyc_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(int sel, logic [DW-1:0] v, string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
  endtask

  task automatic a_wr(int p, logic [AW-1:0] addr, logic [DW-1:0] d);
    we_a[p]           = 1'b1;
    wa_a[p*AW +: AW]  = addr;
    wd_a[p*DW +: DW]  = d;
  endtask

  task automatic a_rd(int k, logic [AW-1:0] addr);
    ra_a[k*AW +: AW] = addr;
  endtask

  task automatic b_rd(int k, logic [AW-1:0] addr);
    ra_b[k*AW +: AW] = addr;
  endtask

  initial begin
    rst = 1'b1;
    clear_a = 1'b0; we_a = '0; wa_a = '0; wd_a = '0; ra_a = '0;
    clear_b = 1'b0; we_b = '0; wa_b = '0; wd_b = '0; ra_b = '0;

    // reset held two cycles, then a full 32-cycle sweep
    step();
    a_rd(0, 5'd1);
    expect_v(S_ABUSY, 32'd1, "reset_busy_a");
    expect_v(S_BBUSY, 32'd1, "reset_busy_b");
    expect_v(S_A0, 32'h0, "reset_read");
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_v(S_ABUSY, 32'd1, "sweep_busy_a");
      expect_v(S_BBUSY, 32'd1, "sweep_busy_b");
      expect_v(S_A0, 32'h0, "sweep_read");
      step();
    end
    expect_v(S_ABUSY, 32'd0, "sweep_done_a");
    expect_v(S_BBUSY, 32'd0, "sweep_done_b");
    for (int a = 0; a < 32; a++) begin
      a_rd(0, a[AW-1:0]);
      a_rd(1, 5'(31 - a));
      b_rd(0, a[AW-1:0]);
      expect_v(S_A0, 32'h0, "post_reset_a0");
      expect_v(S_A1, 32'h0, "post_reset_a1");
      expect_v(S_B0, 32'h0, "post_reset_b0");
      step();
    end

    // basic write with same-cycle bypass
    a_wr(0, 5'd1, 32'h0000_0001);
    a_rd(0, 5'd1); a_rd(1, 5'd2);
    expect_v(S_A0, 32'h0000_0001, "basic_bypass");
    expect_v(S_A1, 32'h0000_0000, "basic_other");
    step();
    we_a = '0;
    expect_v(S_A0, 32'h0000_0001, "basic_after_edge");
    expect_v(S_A1, 32'h0000_0000, "basic_other_after");
    step();

    // zero register, bypassing build
    a_wr(0, 5'd0, 32'hffff_ffff);
    a_rd(0, 5'd0);
    expect_v(S_A0, 32'h0, "zero_bypass");
    step();
    we_a = '0;
    a_wr(0, 5'd31, 32'hffff_ffff);
    a_rd(0, 5'd0); a_rd(1, 5'd31);
    expect_v(S_A0, 32'h0, "zero_after_write");
    expect_v(S_A1, 32'hffff_ffff, "r31_bypass");
    step();
    we_a = '0;
    expect_v(S_A0, 32'h0, "zero_stored");
    expect_v(S_A1, 32'hffff_ffff, "r31_stored");
    step();

    // two ports to one address: port 1 wins
    a_wr(0, 5'd5, 32'h1111_1111);
    a_wr(1, 5'd5, 32'h2222_2222);
    a_rd(0, 5'd5); a_rd(1, 5'd4);
    expect_v(S_A0, 32'h2222_2222, "collide_bypass");
    expect_v(S_A1, 32'h0, "collide_neighbour");
    step();
    we_a = '0;
    expect_v(S_A0, 32'h2222_2222, "collide_stored");
    step();

    // two ports to distinct addresses
    a_wr(0, 5'd6, 32'h6666_6666);
    a_wr(1, 5'd9, 32'h9999_9999);
    a_rd(0, 5'd6); a_rd(1, 5'd9);
    expect_v(S_A0, 32'h6666_6666, "dual_bypass_p0");
    expect_v(S_A1, 32'h9999_9999, "dual_bypass_p1");
    step();
    we_a = '0;
    expect_v(S_A0, 32'h6666_6666, "dual_stored_p0");
    expect_v(S_A1, 32'h9999_9999, "dual_stored_p1");
    step();

    // non-bypassing build: old value until the edge
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hffff_ffff;
    b_rd(0, 5'd0);
    expect_v(S_B0, 32'h0, "nb_zero_write");
    step();
    wa_b = 5'd31; wd_b = 32'hffff_ffff;
    b_rd(0, 5'd31); b_rd(1, 5'd0);
    expect_v(S_B0, 32'h0, "nb_r31_old");
    expect_v(S_B1, 32'h0, "nb_zero_read");
    step();
    wa_b = 5'd3; wd_b = 32'hdead_beef;
    b_rd(0, 5'd3); b_rd(1, 5'd31);
    expect_v(S_B0, 32'h0, "nb_r3_old");
    expect_v(S_B1, 32'hffff_ffff, "nb_r31_new");
    step();
    we_b = 1'b0;
    b_rd(0, 5'd3); b_rd(1, 5'd0);
    expect_v(S_B0, 32'hdead_beef, "nb_r3_new");
    expect_v(S_B1, 32'h0, "nb_zero_stored");
    step();

    // fill 1..31 with their own address
    for (int a = 1; a < 32; a++) begin
      we_a = '0;
      a_wr(0, a[AW-1:0], 32'(a));
      step();
    end
    we_a = '0;
    a_rd(0, 5'd7); a_rd(1, 5'd31);
    expect_v(S_A0, 32'd7, "fill_r7");
    expect_v(S_A1, 32'd31, "fill_r31");
    step();

    // clear request with a concurrent write
    clear_a = 1'b1;
    a_wr(0, 5'd7, 32'haaaa_aaaa);
    a_rd(0, 5'd7); a_rd(1, 5'd30);
    expect_v(S_A0, 32'haaaa_aaaa, "clear_cycle_bypass");
    expect_v(S_A1, 32'd30, "clear_cycle_r30");
    expect_v(S_ABUSY, 32'd0, "clear_cycle_idle");
    step();
    for (int i = 0; i < 32; i++) begin
      clear_a = (i == 20);
      we_a = '0;
      a_wr(0, 5'((i + 31) % 32), 32'h1234_0000 | 32'(i));
      a_rd(0, i[AW-1:0]); a_rd(1, 5'd7);
      expect_v(S_ABUSY, 32'd1, "clear_busy");
      expect_v(S_A0, 32'h0, "clear_read_a0");
      expect_v(S_A1, 32'h0, "clear_read_a1");
      step();
    end
    clear_a = 1'b0;
    we_a = '0;
    expect_v(S_ABUSY, 32'd0, "clear_done");
    for (int a = 0; a < 32; a++) begin
      a_rd(0, a[AW-1:0]);
      a_rd(1, 5'(31 - a));
      expect_v(S_A0, 32'h0, "post_clear_a0");
      expect_v(S_A1, 32'h0, "post_clear_a1");
      step();
    end

    a_wr(0, 5'd12, 32'h5a5a_5a5a);
    step();
    we_a = '0;
    a_rd(0, 5'd12);
    expect_v(S_A0, 32'h5a5a_5a5a, "write_after_clear");
    step();

    // reset at sweep cycle 10 restarts the sweep
    clear_a = 1'b1;
    expect_v(S_ABUSY, 32'd0, "restart_idle");
    step();
    clear_a = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      expect_v(S_ABUSY, 32'd1, "restart_first_busy");
      if (i == 10) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_v(S_ABUSY, 32'd1, "restart_busy_a");
      expect_v(S_BBUSY, 32'd1, "restart_busy_b");
      expect_v(S_A0, 32'h0, "restart_read");
      step();
    end
    expect_v(S_ABUSY, 32'd0, "restart_done_a");
    expect_v(S_BBUSY, 32'd0, "restart_done_b");
    expect_v(S_A0, 32'h0, "restart_r12_cleared");
    step();

    step();
    step();
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
      n_err += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
